// File: rtl/hs32_decode1_pipe.sv
// HS32 decode stage 1: cracks the instruction, reads Rn, forms shift/mask controls, resolves RAW hazards.
// Latency: 1 cycle from accept to valid_o; sustains one instruction per cycle.
// Backpressure: output packet holds while ready_i=0; ready_o drops on a pending packet or a non-forwardable hazard.
module hs32_decode1_pipe #(
    parameter int NSTG = 3,
    parameter int RW   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [31:0]         instr_i,
    output logic [RW-1:0]       rp_addr_o,
    input  logic [31:0]         rp_data_i,
    input  logic [NSTG*RW-1:0]  stg_rd_i,
    input  logic [NSTG-1:0]     stg_wr_i,
    input  logic [NSTG-1:0]     stg_fwd_i,
    input  logic                flush_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [RW-1:0]       rd_o,
    output logic [RW-1:0]       rm_o,
    output logic [31:0]         d2_o,
    output logic [4:0]          shl_o,
    output logic [4:0]          shr_o,
    output logic                sext_o,
    output logic                maskl_o,
    output logic                maskr_o,
    output logic [4:0]          opc_o,
    output logic [NSTG-1:0]     fwd_o,
    output logic                ud_o
);

    typedef struct packed {
        logic [RW-1:0]   rd;
        logic [RW-1:0]   rm;
        logic [31:0]     d2;
        logic [4:0]      shl;
        logic [4:0]      shr;
        logic            sext;
        logic            maskl;
        logic            maskr;
        logic [4:0]      opc;
        logic [NSTG-1:0] fwd;
        logic            ud;
    } pkt_t;

    function automatic logic is_ud(input logic [5:0] op);
        logic def;
        def = (~op[5] & (op[3:2] == 2'b10))
            | (op[5:1] == 5'b00000)
            | (op[5] & ~op[3])
            | (op[5] & (op[3:0] == 4'b1010))
            | (op[5] & (op[3:0] == 4'b1100))
            | (op == 6'b010000);
        return ~def;
    endfunction

    logic [5:0]      opcode;
    logic [RW-1:0]   rn;
    logic [4:0]      sh;
    logic [1:0]      dir;
    logic            ror;
    logic            r_op;
    logic            hit_any;
    logic            stall;
    logic            accept;
    logic [NSTG-1:0] fwd_next;
    pkt_t            pkt_next;
    pkt_t            pkt_q;
    logic            vld_q;

    assign opcode    = instr_i[31:26];
    assign rn        = instr_i[17 -: RW];
    assign sh        = instr_i[13:9];
    assign dir       = instr_i[8:7];
    assign ror       = (dir == 2'b11);
    assign r_op      = opcode[4];
    assign rp_addr_o = rn;

    // Youngest matching stage decides: forward from it, or stall if it cannot forward.
    always_comb begin
        hit_any  = 1'b0;
        stall    = 1'b0;
        fwd_next = '0;
        for (int k = 0; k < NSTG; k++) begin
            if (!hit_any && valid_i && r_op && stg_wr_i[k] &&
                (stg_rd_i[k*RW +: RW] == rn)) begin
                hit_any = 1'b1;
                if (stg_fwd_i[k]) fwd_next[k] = 1'b1;
                else              stall       = 1'b1;
            end
        end
    end

    always_comb begin
        pkt_next       = '0;
        pkt_next.rd    = instr_i[25 -: RW];
        pkt_next.rm    = instr_i[21 -: RW];
        pkt_next.d2    = r_op ? rp_data_i : {{16{instr_i[15]}}, instr_i[15:0]};
        pkt_next.shl   = sh;
        pkt_next.shr   = ror ? (5'd0 - sh) : sh;
        pkt_next.sext  = (dir == 2'b10);
        pkt_next.maskl = ~ror;
        pkt_next.maskr = (dir != 2'b00);
        pkt_next.opc   = {opcode[5], opcode[3:0]};
        pkt_next.fwd   = fwd_next;
        pkt_next.ud    = is_ud(opcode);
    end

    assign ready_o = ~stall & (~vld_q | ready_i);
    assign accept  = valid_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            pkt_q <= '0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
        end else if (accept) begin
            vld_q <= 1'b1;
            pkt_q <= pkt_next;
        end else if (ready_i) begin
            vld_q <= 1'b0;
        end
    end

    assign valid_o = vld_q;
    assign rd_o    = pkt_q.rd;
    assign rm_o    = pkt_q.rm;
    assign d2_o    = pkt_q.d2;
    assign shl_o   = pkt_q.shl;
    assign shr_o   = pkt_q.shr;
    assign sext_o  = pkt_q.sext;
    assign maskl_o = pkt_q.maskl;
    assign maskr_o = pkt_q.maskr;
    assign opc_o   = pkt_q.opc;
    assign fwd_o   = pkt_q.fwd;
    assign ud_o    = pkt_q.ud;

endmodule

// File: tb/tb_hs32_decode1_pipe.sv
// Directed table-driven bench for hs32_decode1_pipe with hand sequences for reset, backpressure and flush.
module tb_hs32_decode1_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] instr_i;
    logic [3:0]  rp_addr_o;
    logic [31:0] rp_data_i;
    logic [11:0] stg_rd_i;
    logic [2:0]  stg_wr_i;
    logic [2:0]  stg_fwd_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  rd_o, rm_o;
    logic [31:0] d2_o;
    logic [4:0]  shl_o, shr_o;
    logic        sext_o, maskl_o, maskr_o;
    logic [4:0]  opc_o;
    logic [2:0]  fwd_o;
    logic        ud_o;

    int checks = 0;
    int errors = 0;

    hs32_decode1_pipe #(.NSTG(3), .RW(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .rp_addr_o(rp_addr_o), .rp_data_i(rp_data_i),
        .stg_rd_i(stg_rd_i), .stg_wr_i(stg_wr_i), .stg_fwd_i(stg_fwd_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .rd_o(rd_o), .rm_o(rm_o), .d2_o(d2_o), .shl_o(shl_o), .shr_o(shr_o),
        .sext_o(sext_o), .maskl_o(maskl_o), .maskr_o(maskr_o), .opc_o(opc_o),
        .fwd_o(fwd_o), .ud_o(ud_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       nm;
        logic [31:0] instr;
        logic [31:0] rpd;
        logic [11:0] srd;
        logic [2:0]  swr;
        logic [2:0]  sfwd;
        logic        rdy;
        logic        vld;
        logic [31:0] d2;
        logic [4:0]  shl;
        logic [4:0]  shr;
        logic        sext;
        logic        ml;
        logic        mr;
        logic [4:0]  opc;
        logic        ud;
        logic [2:0]  fwd;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rpa;
    } vec_t;

    vec_t tv[19];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] rd,
                                       input logic [3:0] rm, input logic [3:0] rn,
                                       input logic [4:0] sh, input logic [1:0] dir);
        return {op, rd, rm, rn, sh, dir, 7'd0};
    endfunction

    function automatic logic [31:0] imm_op(input logic [15:0] imm);
        return {6'b000000, 10'd0, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //          name          instr                               rpd           srd     swr     sfwd    rdy vld d2            shl    shr    sx ml mr opc     ud fwd     rd     rm     rpa
        tv[0]  = '{"imm_neg",    32'h0000FFF0,                       32'h0,        12'h0,   3'b000, 3'b000, 1, 1, 32'hFFFFFFF0, 5'd31, 5'd1,  0, 0, 1, 5'h00, 0, 3'b000, 4'd0,  4'd0, 4'd3};
        tv[1]  = '{"rop_ror",    mk(6'b010000,1,2,5,3,2'b11),        32'h1234,     12'h0,   3'b000, 3'b000, 1, 1, 32'h1234,     5'd3,  5'd29, 0, 0, 1, 5'h00, 0, 3'b000, 4'd1,  4'd2, 4'd5};
        tv[2]  = '{"imm_sext",   mk(6'b001000,3,4,1,5,2'b10),        32'h0,        12'h0,   3'b000, 3'b000, 1, 1, 32'h00004B00, 5'd5,  5'd5,  1, 1, 1, 5'h08, 0, 3'b000, 4'd3,  4'd4, 4'd1};
        tv[3]  = '{"imm_dir0",   mk(6'b100101,15,0,2,0,2'b00),       32'h0,        12'h0,   3'b000, 3'b000, 1, 1, 32'hFFFF8000, 5'd0,  5'd0,  0, 1, 0, 5'h15, 0, 3'b000, 4'd15, 4'd0, 4'd2};
        tv[4]  = '{"ror_sh0",    mk(6'b111010,6,7,9,0,2'b11),        32'hDEADBEEF, 12'h0,   3'b000, 3'b000, 1, 1, 32'hDEADBEEF, 5'd0,  5'd0,  0, 0, 1, 5'h1A, 0, 3'b000, 4'd6,  4'd7, 4'd9};
        tv[5]  = '{"ud_010001",  mk(6'b010001,0,0,0,16,2'b01),       32'h1,        12'h0,   3'b000, 3'b000, 1, 1, 32'h1,        5'd16, 5'd16, 0, 1, 1, 5'h01, 1, 3'b000, 4'd0,  4'd0, 4'd0};
        tv[6]  = '{"def_111100", mk(6'b111100,5,5,4,1,2'b11),        32'h5,        12'h0,   3'b000, 3'b000, 1, 1, 32'h5,        5'd1,  5'd31, 0, 0, 1, 5'h1C, 0, 3'b000, 4'd5,  4'd5, 4'd4};
        tv[7]  = '{"ud_011110",  mk(6'b011110,2,3,3,2,2'b00),        32'hAA,       12'h0,   3'b000, 3'b000, 1, 1, 32'hAA,       5'd2,  5'd2,  0, 1, 0, 5'h0E, 1, 3'b000, 4'd2,  4'd3, 4'd3};
        tv[8]  = '{"def_000001", mk(6'b000001,0,0,0,0,2'b00),        32'h0,        12'h0,   3'b000, 3'b000, 1, 1, 32'h0,        5'd0,  5'd0,  0, 1, 0, 5'h01, 0, 3'b000, 4'd0,  4'd0, 4'd0};
        tv[9]  = '{"ud_101011",  mk(6'b101011,0,0,0,0,2'b00),        32'h0,        12'h0,   3'b000, 3'b000, 1, 1, 32'h0,        5'd0,  5'd0,  0, 1, 0, 5'h1B, 1, 3'b000, 4'd0,  4'd0, 4'd0};
        tv[10] = '{"hz_stall",   mk(6'b010000,1,2,7,0,2'b00),        32'h77,       12'h277, 3'b011, 3'b010, 0, 0, 32'h0,        5'd0,  5'd0,  0, 0, 0, 5'h00, 0, 3'b000, 4'd0,  4'd0, 4'd7};
        tv[11] = '{"hz_fwd0",    mk(6'b010000,1,2,7,0,2'b00),        32'h77,       12'h277, 3'b011, 3'b011, 1, 1, 32'h77,       5'd0,  5'd0,  0, 1, 0, 5'h00, 0, 3'b001, 4'd1,  4'd2, 4'd7};
        tv[12] = '{"hz_fwd1",    mk(6'b010000,1,2,7,0,2'b00),        32'h77,       12'h277, 3'b010, 3'b010, 1, 1, 32'h77,       5'd0,  5'd0,  0, 1, 0, 5'h00, 0, 3'b010, 4'd1,  4'd2, 4'd7};
        tv[13] = '{"hz_miss",    mk(6'b010000,1,2,7,0,2'b00),        32'h77,       12'h277, 3'b100, 3'b100, 1, 1, 32'h77,       5'd0,  5'd0,  0, 1, 0, 5'h00, 0, 3'b000, 4'd1,  4'd2, 4'd7};
        tv[14] = '{"hz_imm",     mk(6'b000000,1,2,7,0,2'b00),        32'h77,       12'h277, 3'b011, 3'b000, 1, 1, 32'hFFFFC000, 5'd0,  5'd0,  0, 1, 0, 5'h00, 0, 3'b000, 4'd1,  4'd2, 4'd7};
        tv[15] = '{"hz_old",     mk(6'b010000,1,2,7,0,2'b00),        32'h77,       12'h777, 3'b111, 3'b110, 0, 0, 32'h0,        5'd0,  5'd0,  0, 0, 0, 5'h00, 0, 3'b000, 4'd0,  4'd0, 4'd7};
        tv[16] = '{"hz_old_fwd", mk(6'b010000,1,2,7,0,2'b00),        32'h77,       12'h777, 3'b110, 3'b010, 1, 1, 32'h77,       5'd0,  5'd0,  0, 1, 0, 5'h00, 0, 3'b010, 4'd1,  4'd2, 4'd7};
        tv[17] = '{"hz_s2",      mk(6'b010000,1,2,7,0,2'b00),        32'h77,       12'h722, 3'b100, 3'b000, 0, 0, 32'h0,        5'd0,  5'd0,  0, 0, 0, 5'h00, 0, 3'b000, 4'd0,  4'd0, 4'd7};
        tv[18] = '{"hz_s2f",     mk(6'b010000,1,2,7,0,2'b00),        32'h77,       12'h722, 3'b111, 3'b100, 1, 1, 32'h77,       5'd0,  5'd0,  0, 1, 0, 5'h00, 0, 3'b100, 4'd1,  4'd2, 4'd7};

        // Reset held for two cycles with a valid instruction presented.
        rst_i     = 1'b1;
        valid_i   = 1'b1;
        instr_i   = imm_op(16'h1234);
        rp_data_i = 32'h0;
        stg_rd_i  = '0;
        stg_wr_i  = '0;
        stg_fwd_i = '0;
        flush_i   = 1'b0;
        ready_i   = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_d2", d2_o, 0);
        chk("rst_ud", ud_o, 0);
        chk("rst_fwd", fwd_o, 0);
        chk("rst_ready", ready_o, 1);
        rst_i = 1'b0;

        for (int i = 0; i < 19; i++) begin
            instr_i   = tv[i].instr;
            rp_data_i = tv[i].rpd;
            stg_rd_i  = tv[i].srd;
            stg_wr_i  = tv[i].swr;
            stg_fwd_i = tv[i].sfwd;
            #1;
            if (i == 0) chk("first_pre_valid", valid_o, 0);
            chk({tv[i].nm, "_ready"}, ready_o, tv[i].rdy);
            chk({tv[i].nm, "_rpaddr"}, rp_addr_o, tv[i].rpa);
            step();
            chk({tv[i].nm, "_valid"}, valid_o, tv[i].vld);
            if (tv[i].vld) begin
                chk({tv[i].nm, "_d2"}, d2_o, tv[i].d2);
                chk({tv[i].nm, "_shl"}, shl_o, tv[i].shl);
                chk({tv[i].nm, "_shr"}, shr_o, tv[i].shr);
                chk({tv[i].nm, "_sext"}, sext_o, tv[i].sext);
                chk({tv[i].nm, "_maskl"}, maskl_o, tv[i].ml);
                chk({tv[i].nm, "_maskr"}, maskr_o, tv[i].mr);
                chk({tv[i].nm, "_opc"}, opc_o, tv[i].opc);
                chk({tv[i].nm, "_ud"}, ud_o, tv[i].ud);
                chk({tv[i].nm, "_fwd"}, fwd_o, tv[i].fwd);
                chk({tv[i].nm, "_rd"}, rd_o, tv[i].rd);
                chk({tv[i].nm, "_rm"}, rm_o, tv[i].rm);
            end
        end

        // Backpressure: packet A must hold while instr_i keeps changing.
        stg_wr_i  = '0;
        stg_fwd_i = '0;
        instr_i   = imm_op(16'h0010);
        step();
        chk("bp_load_d2", d2_o, 32'h10);
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            instr_i = imm_op(16'h0100 + 16'(i));
            #1;
            chk("bp_ready", ready_o, 0);
            step();
            chk("bp_valid", valid_o, 1);
            chk("bp_d2_hold", d2_o, 32'h10);
        end
        ready_i = 1'b1;
        instr_i = imm_op(16'h0222);
        #1;
        chk("bp_release_ready", ready_o, 1);
        step();
        chk("bp_release_valid", valid_o, 1);
        chk("bp_release_d2", d2_o, 32'h222);

        // Flush alongside an accept: incoming instruction is discarded.
        flush_i = 1'b1;
        instr_i = imm_op(16'h0333);
        step();
        chk("flush_valid", valid_o, 0);
        chk("flush_d2_kept", d2_o, 32'h222);
        flush_i = 1'b0;
        instr_i = imm_op(16'h0444);
        step();
        chk("after_flush_valid", valid_o, 1);
        chk("after_flush_d2", d2_o, 32'h444);
        valid_i = 1'b0;
        step();
        chk("drain_valid", valid_o, 0);

        // Flush while a packet is stalled downstream.
        valid_i = 1'b1;
        instr_i = imm_op(16'h0555);
        step();
        chk("pend_valid", valid_o, 1);
        ready_i = 1'b0;
        flush_i = 1'b1;
        instr_i = imm_op(16'h0666);
        step();
        chk("pend_flush_valid", valid_o, 0);
        chk("pend_flush_d2", d2_o, 32'h555);
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs32_decode1_pipe.md
Name: hs32_decode1_pipe

Overview:
Registered, parametrised successor to the first decode stage of the HS32 pipeline. It sits between fetch and execute and performs the following:
- Cracks the 32-bit instruction and reads operand Rn through the regfile read port.
- Forms the shift/mask controls and flags undefined opcodes.
- Resolves data hazards against NSTG downstream write-back stages, each flagged forwardable or stalling.
Output is held in a pipeline register with valid/ready handshake and flush.

Parameters:
NSTG, 3, number of downstream stages checked for RAW hazards; stage 0 is youngest (nearest execute).
RW, 4, register index width (2**RW architectural registers).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
valid_i  in  1  instruction on instr_i is valid
ready_o  out  1  stage accepts instr_i this cycle
instr_i  in  32  opcode[31:26], rd[25:22], rm[21:18], rn[17:14], sh[13:9], dir[8:7]; imm16 = instr_i[15:0]
rp_addr_o  out  RW  regfile read address = rn (combinational)
rp_data_i  in  32  regfile read data (same cycle)
stg_rd_i  in  NSTG*RW  destination register of each stage
stg_wr_i  in  NSTG  stage will write its rd
stg_fwd_i  in  NSTG  stage result is available for forwarding
flush_i  in  1  kill output register and incoming instruction
valid_o  out  1  output packet valid
ready_i  in  1  downstream accepts packet
rd_o, rm_o  out  RW each  registered rd/rm fields
d2_o  out  32  rp_data_i if opcode[4] else sign-extended imm16
shl_o  out  5  sh
shr_o  out  5  ror ? (-sh mod 32) : sh
sext_o  out  1  dir==2'b10
maskl_o  out  1  ~ror, where ror = (dir==2'b11)
maskr_o  out  1  dir!=2'b00
opc_o  out  5  {opcode[5], opcode[3:0]}
fwd_o  out  NSTG  one-hot forwarding source for d2; 0 = use d2_o
ud_o  out  1  undefined opcode

Behaviour:
- Reset (synchronous, active-high; rst_i sampled on clk_i rising edge): valid_o=0; all registered data outputs 0.
- Hazard detection, per stage k (combinational): hit[k] = valid_i & opcode[4] & stg_wr_i[k] & (stg_rd_i[k]==rn).
  - Youngest hit wins: k0 = lowest k with hit[k]=1.
  - stall = hit exists and stg_fwd_i[k0]=0.
  - Otherwise fwd_next = onehot(k0), or 0 if no hit.
  - Older hits are ignored once a younger hit exists.
- ready_o = ~stall & (~valid_o | ready_i). ready_o is combinational and has no dependence on valid_i beyond the hazard terms.
- Accept = valid_i & ready_o. On accept, all outputs load from the decode of instr_i and valid_o<=1 on the next edge (latency 1 cycle).
- valid_o & ready_i & ~accept: valid_o<=0 on the next edge. Covers both the stall case (bubble inserted) and the no-input case.
- valid_o & ~ready_i: all outputs hold stable. Packet must not change while pending.
- flush_i=1: valid_o<=0 next edge, and any simultaneous accept is discarded. Priority: rst_i > flush_i > accept.
- Undefined opcode map (opcode[5:0]); ud_o=0 for:
  - 0?10??
  - 000 00?
  - 1?0???
  - 1?1010
  - 1?1100
  - 010000
  - Every other opcode gives ud_o=1. A ud instruction still flows with valid_o=1; downstream raises the exception.
- shr_o arithmetic is 5-bit two's complement: sh=0 under ror gives 0.
- Hazard checks apply only to R-encoded ops (opcode[4]=1); I-encoded ops never stall.

Test Plan:
1. Reset: rst_i=1 for 2 cycles with valid_i=1 -> valid_o=0, d2_o=0, ud_o=0. First accept after release yields valid_o=1 one cycle later.
2. Immediate op, opcode=6'b000000, imm16=16'hFFF0, ready_i=1 -> next cycle d2_o=32'hFFFFFFF0, fwd_o=0, ud_o=0. Back-to-back issue sustains 1 instr/cycle.
3. R-op with opcode[4]=1, rn=5, dir=2'b11, sh=3, rp_data_i=32'h1234 -> d2_o=32'h1234, shr_o=29, maskl_o=0, maskr_o=1, sext_o=0.
4. Hazards, for an R-op with rn=7:
   - stg_rd = {7,7,2}, stg_wr=3'b011, stg_fwd=3'b010 -> stage 0 hits and is non-forwardable, so ready_o=0 and a bubble appears at the output.
   - Then stg_fwd=3'b011 -> accept with fwd_o=3'b001.
   - With stg_wr=3'b010 -> fwd_o=3'b010.
5. Backpressure: valid_o=1, ready_i=0 for 4 cycles while instr_i changes -> outputs constant and ready_o=0. On ready_i=1 the new instruction loads the next cycle.
6. Flush, and undefined opcode:
   - flush_i=1 in the same cycle as an accept -> valid_o=0 next cycle.
   - Opcode 6'b010001 -> ud_o=1, valid_o=1.
   - Opcode 6'b010000 -> ud_o=0.
